// File: rtl/ucode_pkg.sv
// ucode_pkg: shared definitions for the microcode sequencer.
//  - micro-op opcode encodings and 28-bit micro-op word layout (field offsets + struct)
//  - ENTRY table: micro-ROM entry point per macro-op (0=MUL, 1=POPCNT, 2=ABSDIFF, 3=reserved)
//  - sequencer state enum
//  - uop(): builds a micro-op word from its fields, used by the ROM table
package ucode_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_AW = 4;
  localparam int unsigned OP_W   = 4;
  localparam int unsigned IMM_W  = 12;
  localparam int unsigned UOP_W  = OP_W + 3 * REG_AW + IMM_W;

  // Field offsets inside the micro-op word {op, rd, rs1, rs2, imm}
  localparam int unsigned IMM_LSB = 0;
  localparam int unsigned RS2_LSB = IMM_LSB + IMM_W;
  localparam int unsigned RS1_LSB = RS2_LSB + REG_AW;
  localparam int unsigned RD_LSB  = RS1_LSB + REG_AW;
  localparam int unsigned OP_LSB  = RD_LSB + REG_AW;

  typedef enum logic [OP_W-1:0] {
    OP_NOP  = 4'h0,
    OP_LDA  = 4'h1,
    OP_LDB  = 4'h2,
    OP_MOVI = 4'h3,
    OP_ADD  = 4'h4,
    OP_SUB  = 4'h5,
    OP_AND  = 4'h6,
    OP_SHL1 = 4'h7,
    OP_SHR1 = 4'h8,
    OP_SLTU = 4'h9,
    OP_BNZ  = 4'hA,
    OP_OUT  = 4'hB,
    OP_END  = 4'hC
  } uop_e;

  typedef struct packed {
    uop_e              op;
    logic [REG_AW-1:0] rd;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [IMM_W-1:0]  imm;
  } uop_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Micro-ROM entry point per macro-op
  localparam int unsigned ENTRY [4] = '{32'd0, 32'd16, 32'd32, 32'd48};

  function automatic uop_t uop(input uop_e op, input logic [REG_AW-1:0] rd,
                               input logic [REG_AW-1:0] rs1, input logic [REG_AW-1:0] rs2,
                               input logic [IMM_W-1:0] imm);
    logic [UOP_W-1:0] w;
    w = '0;
    w[OP_LSB  +: OP_W]   = op;
    w[RD_LSB  +: REG_AW] = rd;
    w[RS1_LSB +: REG_AW] = rs1;
    w[RS2_LSB +: REG_AW] = rs2;
    w[IMM_LSB +: IMM_W]  = imm;
    return uop_t'(w);
  endfunction

endpackage

// File: rtl/ucode_sequencer_if.sv
// ucode_sequencer_if: macro-op request bus plus ghost register file port.
//  start/macro_op/op_a/op_b/hold        requester -> sequencer
//  busy/done/err/result                 sequencer -> requester
//  g_rd/g_rs1/g_rs2/g_write/g_wdata     sequencer -> ghost file
//  g_rs1_data/g_rs2_data                ghost file -> sequencer (combinational read)
//  modport slave  : the sequencer
//  modport master : requester + ghost file side
interface ucode_sequencer_if;
  import ucode_pkg::*;

  logic              start;
  logic [1:0]        macro_op;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              hold;
  logic              busy;
  logic              done;
  logic              err;
  logic [DATA_W-1:0] result;
  logic [REG_AW-1:0] g_rd;
  logic [REG_AW-1:0] g_rs1;
  logic [REG_AW-1:0] g_rs2;
  logic              g_write;
  logic [DATA_W-1:0] g_wdata;
  logic [DATA_W-1:0] g_rs1_data;
  logic [DATA_W-1:0] g_rs2_data;

  modport slave (
    input  start, macro_op, op_a, op_b, hold, g_rs1_data, g_rs2_data,
    output busy, done, err, result, g_rd, g_rs1, g_rs2, g_write, g_wdata
  );

  modport master (
    output start, macro_op, op_a, op_b, hold, g_rs1_data, g_rs2_data,
    input  busy, done, err, result, g_rd, g_rs1, g_rs2, g_write, g_wdata
  );

endinterface

// File: rtl/ucode_rom.sv
// ucode_rom: asynchronous-read micro-ROM holding the four macro-op programs.
//  i_addr   in  UPC_W  micro-PC
//  o_uop_c  out 28     micro-op word at i_addr (combinational)
// Unlisted addresses read as NOP.
module ucode_rom
  import ucode_pkg::*;
#(
  parameter int unsigned UPC_W = 6
) (
  input  logic [UPC_W-1:0] i_addr,
  output uop_t             o_uop_c
);

  always_comb begin
    o_uop_c = '0;
    case (32'(i_addr))
      // MUL: shift-add over the bits of b; r1=a (shifted), r2=b, r3=acc, r4=1
      0:  o_uop_c = uop(OP_LDA,  4'd1, 4'd0, 4'd0, 12'd0);
      1:  o_uop_c = uop(OP_LDB,  4'd2, 4'd0, 4'd0, 12'd0);
      2:  o_uop_c = uop(OP_MOVI, 4'd3, 4'd0, 4'd0, 12'd0);
      3:  o_uop_c = uop(OP_MOVI, 4'd4, 4'd0, 4'd0, 12'd1);
      4:  o_uop_c = uop(OP_BNZ,  4'd0, 4'd2, 4'd0, 12'd6);
      5:  o_uop_c = uop(OP_BNZ,  4'd0, 4'd4, 4'd0, 12'd14);  // r4==1: unconditional jump
      6:  o_uop_c = uop(OP_AND,  4'd5, 4'd2, 4'd4, 12'd0);
      7:  o_uop_c = uop(OP_BNZ,  4'd0, 4'd5, 4'd0, 12'd12);
      8:  o_uop_c = uop(OP_SHL1, 4'd1, 4'd1, 4'd0, 12'd0);
      9:  o_uop_c = uop(OP_SHR1, 4'd2, 4'd2, 4'd0, 12'd0);
      10: o_uop_c = uop(OP_BNZ,  4'd0, 4'd2, 4'd0, 12'd6);
      11: o_uop_c = uop(OP_BNZ,  4'd0, 4'd4, 4'd0, 12'd14);
      12: o_uop_c = uop(OP_ADD,  4'd3, 4'd3, 4'd1, 12'd0);
      13: o_uop_c = uop(OP_BNZ,  4'd0, 4'd4, 4'd0, 12'd8);
      14: o_uop_c = uop(OP_OUT,  4'd0, 4'd3, 4'd0, 12'd0);
      15: o_uop_c = uop(OP_END,  4'd0, 4'd0, 4'd0, 12'd0);
      // POPCNT: accumulate bit 0 while shifting a right until zero
      16: o_uop_c = uop(OP_LDA,  4'd1, 4'd0, 4'd0, 12'd0);
      17: o_uop_c = uop(OP_MOVI, 4'd3, 4'd0, 4'd0, 12'd0);
      18: o_uop_c = uop(OP_MOVI, 4'd4, 4'd0, 4'd0, 12'd1);
      19: o_uop_c = uop(OP_AND,  4'd5, 4'd1, 4'd4, 12'd0);
      20: o_uop_c = uop(OP_ADD,  4'd3, 4'd3, 4'd5, 12'd0);
      21: o_uop_c = uop(OP_SHR1, 4'd1, 4'd1, 4'd0, 12'd0);
      22: o_uop_c = uop(OP_BNZ,  4'd0, 4'd1, 4'd0, 12'd19);
      23: o_uop_c = uop(OP_OUT,  4'd0, 4'd3, 4'd0, 12'd0);
      24: o_uop_c = uop(OP_END,  4'd0, 4'd0, 4'd0, 12'd0);
      // ABSDIFF: subtract the smaller operand from the larger
      32: o_uop_c = uop(OP_LDA,  4'd1, 4'd0, 4'd0, 12'd0);
      33: o_uop_c = uop(OP_LDB,  4'd2, 4'd0, 4'd0, 12'd0);
      34: o_uop_c = uop(OP_SLTU, 4'd5, 4'd1, 4'd2, 12'd0);
      35: o_uop_c = uop(OP_BNZ,  4'd0, 4'd5, 4'd0, 12'd39);
      36: o_uop_c = uop(OP_SUB,  4'd3, 4'd1, 4'd2, 12'd0);
      37: o_uop_c = uop(OP_OUT,  4'd0, 4'd3, 4'd0, 12'd0);
      38: o_uop_c = uop(OP_END,  4'd0, 4'd0, 4'd0, 12'd0);
      39: o_uop_c = uop(OP_SUB,  4'd3, 4'd2, 4'd1, 12'd0);
      40: o_uop_c = uop(OP_OUT,  4'd0, 4'd3, 4'd0, 12'd0);
      41: o_uop_c = uop(OP_END,  4'd0, 4'd0, 4'd0, 12'd0);
      // Reserved macro-op: r0 is zeroed first so the result never depends on stale state
      48: o_uop_c = uop(OP_MOVI, 4'd0, 4'd0, 4'd0, 12'd0);
      49: o_uop_c = uop(OP_OUT,  4'd0, 4'd0, 4'd0, 12'd0);
      50: o_uop_c = uop(OP_END,  4'd0, 4'd0, 4'd0, 12'd0);
      default: o_uop_c = '0;
    endcase
  end

endmodule

// File: rtl/ucode_sequencer.sv
// ucode_sequencer: steps the micro-ROM one micro-op per cycle on behalf of a macro-op,
// driving the ghost register file read/write ports and returning a 32-bit result.
//  clk, rst  clock; synchronous active-high reset
//  bus       ucode_sequencer_if.slave (request handshake + ghost file port)
// Optional: UCODE_WATCHDOG_EN adds a step counter that aborts a program after MAX_STEPS
// executed micro-ops (done+err, result 0). Without it err is tied low.
module ucode_sequencer
  import ucode_pkg::*;
#(
  parameter int unsigned UPC_W     = 6,
  parameter int unsigned MAX_STEPS = 256
) (
  input  logic               clk,
  input  logic               rst,
  ucode_sequencer_if.slave   bus
);

  state_e            r_state, w_state_nxt;
  logic [UPC_W-1:0]  r_upc, w_upc_nxt;
  logic [DATA_W-1:0] r_result, w_result_nxt;
  logic              r_err, w_err_nxt;
  logic              w_abort;
  uop_t              w_uop;

  logic              w_g_write_c;
  logic [REG_AW-1:0] w_g_rd_c, w_g_rs1_c, w_g_rs2_c;
  logic [DATA_W-1:0] w_g_wdata_c;

  ucode_rom #(.UPC_W(UPC_W)) u_rom (
    .i_addr  (r_upc),
    .o_uop_c (w_uop)
  );

`ifdef UCODE_WATCHDOG_EN
  localparam int unsigned STEP_W = $clog2(MAX_STEPS + 1);
  logic [STEP_W-1:0] r_steps;

  // Counts executed (non-held) micro-ops of the current macro-op
  always_ff @(posedge clk) begin
    if (rst) begin
      r_steps <= '0;
    end else if (r_state == ST_IDLE && bus.start) begin
      r_steps <= '0;
    end else if (r_state == ST_EXEC && !bus.hold && !w_abort) begin
      r_steps <= r_steps + STEP_W'(1);
    end
  end

  assign w_abort = (r_steps == STEP_W'(MAX_STEPS));
`else
  // MAX_STEPS only matters when the watchdog is built in
  logic w_unused_cfg;
  assign w_unused_cfg = ^32'(MAX_STEPS);
  assign w_abort      = 1'b0;
`endif

  // State, micro-PC and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_upc    <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_upc    <= w_upc_nxt;
      r_result <= w_result_nxt;
      r_err    <= w_err_nxt;
    end
  end

  // Next-state and micro-op execution; ghost ports are only driven by a live, non-held EXEC cycle
  always_comb begin
    w_state_nxt  = r_state;
    w_upc_nxt    = r_upc;
    w_result_nxt = r_result;
    w_err_nxt    = 1'b0;
    w_g_write_c  = 1'b0;
    w_g_rd_c     = '0;
    w_g_rs1_c    = '0;
    w_g_rs2_c    = '0;
    w_g_wdata_c  = '0;

    unique case (r_state)
      ST_IDLE: begin
        if (bus.start) begin
          w_upc_nxt   = UPC_W'(ENTRY[bus.macro_op]);
          w_state_nxt = ST_EXEC;
        end
      end

      ST_EXEC: begin
        if (!bus.hold) begin
          if (w_abort) begin
            w_state_nxt  = ST_DONE;
            w_err_nxt    = 1'b1;
            w_result_nxt = '0;
          end else begin
            w_upc_nxt = r_upc + UPC_W'(1);
            case (w_uop.op)
              OP_LDA: begin
                w_g_rd_c    = w_uop.rd;
                w_g_write_c = 1'b1;
                w_g_wdata_c = bus.op_a;
              end
              OP_LDB: begin
                w_g_rd_c    = w_uop.rd;
                w_g_write_c = 1'b1;
                w_g_wdata_c = bus.op_b;
              end
              OP_MOVI: begin
                w_g_rd_c    = w_uop.rd;
                w_g_write_c = 1'b1;
                w_g_wdata_c = DATA_W'(w_uop.imm);
              end
              OP_ADD, OP_SUB, OP_AND, OP_SLTU: begin
                w_g_rd_c    = w_uop.rd;
                w_g_rs1_c   = w_uop.rs1;
                w_g_rs2_c   = w_uop.rs2;
                w_g_write_c = 1'b1;
                case (w_uop.op)
                  OP_ADD:  w_g_wdata_c = bus.g_rs1_data + bus.g_rs2_data;
                  OP_SUB:  w_g_wdata_c = bus.g_rs1_data - bus.g_rs2_data;
                  OP_AND:  w_g_wdata_c = bus.g_rs1_data & bus.g_rs2_data;
                  default: w_g_wdata_c = DATA_W'(bus.g_rs1_data < bus.g_rs2_data);
                endcase
              end
              OP_SHL1: begin
                w_g_rd_c    = w_uop.rd;
                w_g_rs1_c   = w_uop.rs1;
                w_g_write_c = 1'b1;
                w_g_wdata_c = {bus.g_rs1_data[DATA_W-2:0], 1'b0};
              end
              OP_SHR1: begin
                w_g_rd_c    = w_uop.rd;
                w_g_rs1_c   = w_uop.rs1;
                w_g_write_c = 1'b1;
                w_g_wdata_c = {1'b0, bus.g_rs1_data[DATA_W-1:1]};
              end
              OP_BNZ: begin
                w_g_rs1_c = w_uop.rs1;
                if (bus.g_rs1_data != '0) begin
                  w_upc_nxt = w_uop.imm[UPC_W-1:0];
                end
              end
              OP_OUT: begin
                w_g_rs1_c    = w_uop.rs1;
                w_result_nxt = bus.g_rs1_data;
              end
              OP_END: begin
                w_state_nxt = ST_DONE;
              end
              default: ;  // NOP and reserved opcodes
            endcase
          end
        end
      end

      ST_DONE: w_state_nxt = ST_IDLE;

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign bus.busy    = (r_state == ST_EXEC);
  assign bus.done    = (r_state == ST_DONE);
  assign bus.err     = r_err;
  assign bus.result  = r_result;
  assign bus.g_write = w_g_write_c;
  assign bus.g_rd    = w_g_rd_c;
  assign bus.g_rs1   = w_g_rs1_c;
  assign bus.g_rs2   = w_g_rs2_c;
  assign bus.g_wdata = w_g_wdata_c;

endmodule

// File: tb/tb_ucode_sequencer.sv
// tb_ucode_sequencer: directed macro-op vectors against an arithmetic reference model,
// with a ghost register file model attached to the sequencer's ghost port.
module tb_ucode_sequencer;
  import ucode_pkg::*;

`ifdef UCODE_WATCHDOG_EN
  localparam int unsigned MS = 8;
`else
  localparam int unsigned MS = 256;
`endif
  localparam int BUDGET = 500;

  logic clk;
  logic rst;
  ucode_sequencer_if bus ();

  ucode_sequencer #(.UPC_W(6), .MAX_STEPS(MS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Ghost register file: combinational read, write at posedge, cleared by rst
  logic [31:0] gf [16];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) gf[i] <= '0;
    end else if (bus.g_write) begin
      gf[bus.g_rd] <= bus.g_wdata;
    end
  end
  assign bus.g_rs1_data = gf[bus.g_rs1];
  assign bus.g_rs2_data = gf[bus.g_rs2];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: what each macro-op must return
  function automatic logic [31:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'd0:    return a * b;
      2'd1:    return 32'($countones(a));
      2'd2:    return (a > b) ? (a - b) : (b - a);
      default: return 32'd0;
    endcase
  endfunction

  // Expectations for the macro-op in flight (written only by the stimulus process)
  logic [31:0] m_exp_res = '0;
  logic [31:0] m_exp_lit = '0;
  logic        m_exp_err = 1'b0;
  int          m_exp_lat = -1;

  // Compare-process state and counters
  int   n_total = 0;
  int   n_bad   = 0;
  bit   m_active = 1'b0;
  bit   m_post = 1'b0;
  bit   m_was_done = 1'b0;
  int   m_lat = 0;
  int   m_last_lat = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Single compare process: checks outputs every cycle just after the active edge
  always @(posedge clk) begin
    logic st, r;
    st = bus.start;
    r  = rst;
    #1;
    if (r) begin
      m_active = 1'b0;
      m_post   = 1'b0;
      chk("rst_busy",   32'(bus.busy), 32'd0);
      chk("rst_done",   32'(bus.done), 32'd0);
      chk("rst_err",    32'(bus.err),  32'd0);
      chk("rst_result", bus.result,    32'd0);
    end else begin
      if (m_post) begin
        chk("result_held", bus.result, m_exp_res);
        m_post = 1'b0;
      end
      if (!m_active && !m_was_done && st) begin
        m_active = 1'b1;
        m_lat    = 0;
      end
      if (m_active) begin
        if (bus.done) begin
          chk("done_busy",    32'(bus.busy), 32'd0);
          chk("result_model", bus.result,    m_exp_res);
          chk("result_lit",   bus.result,    m_exp_lit);
          chk("done_err",     32'(bus.err),  32'(m_exp_err));
          if (m_exp_lat >= 0) chk("latency", 32'(m_lat), 32'(m_exp_lat));
          m_last_lat = m_lat;
          m_active   = 1'b0;
          m_post     = 1'b1;
        end else begin
          chk("busy_run", 32'(bus.busy), 32'd1);
          m_lat++;
          if (m_lat > BUDGET) begin
            n_total++;
            n_bad++;
            $display("FAIL timeout: no done after %0d cycles", m_lat);
            m_active = 1'b0;
          end
        end
      end else begin
        chk("idle_busy", 32'(bus.busy), 32'd0);
        chk("idle_done", 32'(bus.done), 32'd0);
      end
      if (!bus.done) chk("err_quiet", 32'(bus.err), 32'd0);
      if (bus.g_write) chk("write_gate", 32'(bus.busy && !bus.hold), 32'd1);
    end
    m_was_done = bus.done;
  end

  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] lit, input logic err, input int exp_lat);
    @(negedge clk);
    m_exp_res    = err ? 32'd0 : model(op, a, b);
    m_exp_lit    = lit;
    m_exp_err    = err;
    m_exp_lat    = exp_lat;
    bus.macro_op = op;
    bus.op_a     = a;
    bus.op_b     = b;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  task automatic wait_done(input int hold_at, input int hold_len);
    for (int i = 0; i < BUDGET + 20; i++) begin
      if (bus.done) break;
      bus.hold = (i >= hold_at) && (i < hold_at + hold_len);
      @(negedge clk);
    end
    bus.hold = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] lit, input logic err, input int exp_lat,
                        input int hold_at, input int hold_len);
    start_op(op, a, b, lit, err, exp_lat);
    wait_done(hold_at, hold_len);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int base_lat;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.macro_op = 2'd0;
    bus.op_a     = '0;
    bus.op_b     = '0;
    bus.hold     = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // b=0: shortest MUL path, exactly 8 micro-ops
    run_op(2'd0, 32'h0000_1234, 32'd0, 32'd0, 1'b0, 8, 0, 0);
`ifdef UCODE_WATCHDOG_EN
    // Runaway-length MUL hits the 8-step limit: 8 executed ops + 1 abort cycle
    run_op(2'd0, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1, 9, 0, 0);
    run_op(2'd2, 32'd3, 32'd10, 32'd7, 1'b0, -1, 0, 0);
    run_op(2'd2, 32'd10, 32'd3, 32'd7, 1'b0, -1, 0, 0);
    run_op(2'd3, 32'd0, 32'd0, 32'd0, 1'b0, 3, 0, 0);
    start_op(2'd0, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1, -1);
    repeat (4) @(negedge clk);
    pulse_reset();
    run_op(2'd2, 32'd3, 32'd10, 32'd7, 1'b0, -1, 0, 0);
`else
    run_op(2'd0, 32'd6, 32'd7, 32'd42, 1'b0, -1, 0, 0);
    run_op(2'd0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b0, -1, 0, 0);
    run_op(2'd1, 32'hF0F0_0001, 32'd0, 32'd9, 1'b0, -1, 0, 0);
    run_op(2'd1, 32'd0, 32'd0, 32'd0, 1'b0, 9, 0, 0);
    run_op(2'd2, 32'd3, 32'd10, 32'd7, 1'b0, 7, 0, 0);
    run_op(2'd2, 32'd10, 32'd3, 32'd7, 1'b0, 7, 0, 0);
    run_op(2'd3, 32'd0, 32'd0, 32'd0, 1'b0, 3, 0, 0);
    run_op(2'd2, 32'd5, 32'd5, 32'd0, 1'b0, -1, 0, 0);

    // Hold for 3 cycles mid-MUL must delay done by exactly 3
    run_op(2'd0, 32'd5, 32'd5, 32'd25, 1'b0, -1, 0, 0);
    base_lat = m_last_lat;
    run_op(2'd0, 32'd5, 32'd5, 32'd25, 1'b0, base_lat + 3, 4, 3);

    // Reset in the middle of a MUL, after a nonzero result was left on the port
    run_op(2'd0, 32'd3, 32'd3, 32'd9, 1'b0, -1, 0, 0);
    start_op(2'd0, 32'd5, 32'd5, 32'd25, 1'b0, -1);
    repeat (6) @(negedge clk);
    pulse_reset();
    run_op(2'd0, 32'd6, 32'd7, 32'd42, 1'b0, -1, 0, 0);
`endif

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
